// File: rtl/pipeline_hazard_ctrl_pkg.sv
// ============================================================================
// Module      : pipeline_hazard_ctrl_pkg
// Description : Shared state encodings and constants for the hazard controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipeline_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FILL     = 2'd1,
    ST_RUN      = 2'd2,
    ST_REDIRECT = 2'd3
  } state_t;

  localparam logic [4:0]  REG_ZERO     = 5'd0;
  localparam logic [31:0] BUBBLE_INSTR = 32'h0;

  // A source operand collides with the load destination only if it is actually read.
  function automatic logic src_hit(input logic uses, input logic [4:0] rs,
                                   input logic [4:0] rd);
    return uses && (rs == rd);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that sticks at all-ones instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] C_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] C_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      count <= '0;
    end else if (inc && (count != C_MAX)) begin
      count <= count + C_ONE;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
// ============================================================================
// Module      : pipeline_hazard_ctrl
// Description : 5-stage pipeline sequencer: fill bubbles, load-use stall,
//               MEM-stage redirect flush and performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int IMEM_LAT = 1,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             enable,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             mem_branch,
  input  logic             mem_zero,
  input  logic             mem_jump,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic [1:0]       ctrl_state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] active_cnt
);

  localparam logic [1:0] C_LAT = 2'(IMEM_LAT);

  state_t     r_state;
  logic [1:0] r_bubble;
  logic       w_redirect;
  logic       w_load_use;
  logic       w_stall_inc;
  logic       w_flush_inc;
  logic       w_active_inc;

  assign w_redirect = mem_jump | (mem_branch & mem_zero);
  assign w_load_use = ex_mem_read && (ex_rd != REG_ZERO) &&
                      (src_hit(id_uses_rs1, id_rs1, ex_rd) ||
                       src_hit(id_uses_rs2, id_rs2, ex_rd));

  always_comb begin
    pc_en        = 1'b0;
    if_id_en     = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    if (enable) begin
      unique case (r_state)
        ST_IDLE: ;
        ST_FILL: begin
          pc_en       = 1'b1;
          if_id_en    = 1'b1;
          if_id_flush = 1'b1;
        end
        ST_RUN, ST_REDIRECT: begin
          if (w_redirect) begin
            pc_en        = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
          end else if (r_state == ST_REDIRECT) begin
            // Bubbles carry no register uses, so load-use is irrelevant here.
            pc_en       = 1'b1;
            if_id_en    = 1'b1;
            if_id_flush = 1'b1;
          end else if (w_load_use) begin
            id_ex_flush = 1'b1;
          end else begin
            pc_en    = 1'b1;
            if_id_en = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state  <= ST_IDLE;
      r_bubble <= 2'd0;
    end else if (!enable) begin
      r_state  <= ST_IDLE;
      r_bubble <= 2'd0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          r_state  <= ST_FILL;
          r_bubble <= C_LAT;
        end
        ST_FILL: begin
          if (r_bubble <= 2'd1) r_state <= ST_RUN;
          else                  r_bubble <= r_bubble - 2'd1;
        end
        ST_RUN: begin
          if (w_redirect) begin
            r_state  <= ST_REDIRECT;
            r_bubble <= C_LAT;
          end
        end
        ST_REDIRECT: begin
          if (w_redirect)            r_bubble <= C_LAT;
          else if (r_bubble <= 2'd1) r_state  <= ST_RUN;
          else                       r_bubble <= r_bubble - 2'd1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign ctrl_state   = r_state;
  assign w_stall_inc  = enable && (r_state == ST_RUN) && !w_redirect && w_load_use;
  assign w_flush_inc  = enable && ((r_state == ST_RUN) || (r_state == ST_REDIRECT)) && w_redirect;
  assign w_active_inc = enable && (r_state != ST_IDLE);

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk(clk), .arst_n(arst_n), .inc(w_stall_inc), .count(stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk(clk), .arst_n(arst_n), .inc(w_flush_inc), .count(flush_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_active_cnt (
    .clk(clk), .arst_n(arst_n), .inc(w_active_inc), .count(active_cnt)
  );

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
// ============================================================================
// Module      : tb_pipeline_hazard_ctrl
// Description : Directed vector bench; dut_a has IMEM_LAT=1/CNT_W=4,
//               dut_b has IMEM_LAT=2/CNT_W=32.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipeline_hazard_ctrl;

  typedef struct {
    bit        sel;
    bit        en;
    logic [4:0] rs1, rs2;
    bit        u1, u2;
    logic [4:0] rd;
    bit        mr, br, z, j;
    logic [4:0] o;     // {pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_flush}
    logic [1:0] st;
    int        s, f, a;
  } vec_t;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  logic en_a = 1'b0, en_b = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0, ex_mem_read = 1'b0;
  logic mem_branch = 1'b0, mem_zero = 1'b0, mem_jump = 1'b0;

  logic pc_a, ifen_a, iff_a, ief_a, emf_a;
  logic pc_b, ifen_b, iff_b, ief_b, emf_b;
  logic [1:0] st_a, st_b;
  logic [3:0] stall_a, flush_a, active_a;
  logic [31:0] stall_b, flush_b, active_b;

  int n_err = 0;
  int n_checks = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.IMEM_LAT(1), .CNT_W(4)) dut_a (
    .clk(clk), .arst_n(arst_n), .enable(en_a),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .mem_branch(mem_branch), .mem_zero(mem_zero), .mem_jump(mem_jump),
    .pc_en(pc_a), .if_id_en(ifen_a), .if_id_flush(iff_a), .id_ex_flush(ief_a),
    .ex_mem_flush(emf_a), .ctrl_state(st_a),
    .stall_cnt(stall_a), .flush_cnt(flush_a), .active_cnt(active_a)
  );

  pipeline_hazard_ctrl #(.IMEM_LAT(2), .CNT_W(32)) dut_b (
    .clk(clk), .arst_n(arst_n), .enable(en_b),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .mem_branch(mem_branch), .mem_zero(mem_zero), .mem_jump(mem_jump),
    .pc_en(pc_b), .if_id_en(ifen_b), .if_id_flush(iff_b), .id_ex_flush(ief_b),
    .ex_mem_flush(emf_b), .ctrl_state(st_b),
    .stall_cnt(stall_b), .flush_cnt(flush_b), .active_cnt(active_b)
  );

  task automatic chk(input string nm, input int idx, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s vec=%0d got=%0h expected=%0h", nm, idx, got, exp);
    end
  endtask

  function automatic vec_t mk(input bit sel, input bit en,
                              input logic [4:0] rs1, input logic [4:0] rs2,
                              input bit u1, input bit u2, input logic [4:0] rd,
                              input bit mr, input bit br, input bit z, input bit j,
                              input logic [4:0] o, input logic [1:0] st,
                              input int s, input int f, input int a);
    vec_t v;
    v.sel = sel; v.en = en; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2;
    v.rd = rd; v.mr = mr; v.br = br; v.z = z; v.j = j;
    v.o = o; v.st = st; v.s = s; v.f = f; v.a = a;
    return v;
  endfunction

  // Drive one vector, check the same-cycle outputs and pre-edge counters, then clock.
  task automatic apply(input vec_t v, input int idx);
    en_a = !v.sel && v.en;
    en_b = v.sel && v.en;
    id_rs1 = v.rs1; id_rs2 = v.rs2; id_uses_rs1 = v.u1; id_uses_rs2 = v.u2;
    ex_rd = v.rd; ex_mem_read = v.mr; mem_branch = v.br; mem_zero = v.z; mem_jump = v.j;
    #1;
    if (v.sel) begin
      chk("ctrl_b", idx, 32'({pc_b, ifen_b, iff_b, ief_b, emf_b}), 32'(v.o));
      chk("state_b", idx, 32'(st_b), 32'(v.st));
      chk("stall_b", idx, stall_b, v.s);
      chk("flush_b", idx, flush_b, v.f);
      chk("active_b", idx, active_b, v.a);
    end else begin
      chk("ctrl_a", idx, 32'({pc_a, ifen_a, iff_a, ief_a, emf_a}), 32'(v.o));
      chk("state_a", idx, 32'(st_a), 32'(v.st));
      chk("stall_a", idx, 32'(stall_a), v.s);
      chk("flush_a", idx, 32'(flush_a), v.f);
      chk("active_a", idx, 32'(active_a), v.a);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n_a, n_b;
    // dut_a, IMEM_LAT=1
    tbl.push_back(mk(0,0, 0,0,0,0,0, 0,0,0,0, 5'b00000, 0, 0,0,0));
    tbl.push_back(mk(0,1, 0,0,0,0,0, 0,0,0,0, 5'b00000, 0, 0,0,0));
    tbl.push_back(mk(0,1, 0,0,0,0,0, 0,0,0,0, 5'b11100, 1, 0,0,0));
    tbl.push_back(mk(0,1, 0,0,0,0,0, 0,0,0,0, 5'b11000, 2, 0,0,1));
    tbl.push_back(mk(0,1, 0,5,0,1,5, 1,0,0,0, 5'b00010, 2, 0,0,2));
    tbl.push_back(mk(0,1, 0,0,0,0,0, 0,0,0,0, 5'b11000, 2, 1,0,3));
    tbl.push_back(mk(0,1, 0,5,0,1,0, 1,0,0,0, 5'b11000, 2, 1,0,4));
    tbl.push_back(mk(0,1, 7,0,1,0,7, 1,0,0,0, 5'b00010, 2, 1,0,5));
    tbl.push_back(mk(0,1, 7,0,0,0,7, 1,0,0,0, 5'b11000, 2, 2,0,6));
    tbl.push_back(mk(0,1, 0,3,0,1,3, 0,0,0,0, 5'b11000, 2, 2,0,7));
    tbl.push_back(mk(0,1, 0,0,0,0,0, 0,1,0,0, 5'b11000, 2, 2,0,8));
    tbl.push_back(mk(0,1, 0,0,0,0,0, 0,1,1,0, 5'b10111, 2, 2,0,9));
    tbl.push_back(mk(0,1, 0,0,0,0,0, 0,0,0,0, 5'b11100, 3, 2,1,10));
    tbl.push_back(mk(0,1, 4,0,1,0,4, 1,0,0,1, 5'b10111, 2, 2,1,11));
    tbl.push_back(mk(0,1, 4,0,1,0,4, 1,0,0,0, 5'b11100, 3, 2,2,12));
    tbl.push_back(mk(0,1, 0,0,0,0,0, 0,0,0,0, 5'b11000, 2, 2,2,13));
    tbl.push_back(mk(0,0, 0,0,0,0,0, 0,0,0,0, 5'b00000, 2, 2,2,14));
    tbl.push_back(mk(0,0, 0,0,0,0,0, 0,0,0,0, 5'b00000, 0, 2,2,14));
    tbl.push_back(mk(0,1, 4,0,1,0,4, 1,0,0,0, 5'b00000, 0, 2,2,14));
    tbl.push_back(mk(0,1, 0,0,0,0,0, 0,0,0,0, 5'b11100, 1, 2,2,14));
    tbl.push_back(mk(0,1, 0,0,0,0,0, 0,0,0,0, 5'b11000, 2, 2,2,15));
    tbl.push_back(mk(0,1, 0,0,0,0,0, 0,0,0,0, 5'b11000, 2, 2,2,15));
    n_a = tbl.size();
    // dut_b, IMEM_LAT=2
    tbl.push_back(mk(1,1, 0,0,0,0,0, 0,0,0,0, 5'b00000, 0, 0,0,0));
    tbl.push_back(mk(1,1, 0,0,0,0,0, 0,0,0,0, 5'b11100, 1, 0,0,0));
    tbl.push_back(mk(1,1, 0,0,0,0,0, 0,0,0,0, 5'b11100, 1, 0,0,1));
    tbl.push_back(mk(1,1, 0,0,0,0,0, 0,0,0,0, 5'b11000, 2, 0,0,2));
    tbl.push_back(mk(1,1, 0,0,0,0,0, 0,1,1,0, 5'b10111, 2, 0,0,3));
    tbl.push_back(mk(1,1, 0,0,0,0,0, 0,0,0,0, 5'b11100, 3, 0,1,4));
    tbl.push_back(mk(1,1, 0,0,0,0,0, 0,0,0,0, 5'b11100, 3, 0,1,5));
    tbl.push_back(mk(1,1, 0,0,0,0,0, 0,0,0,0, 5'b11000, 2, 0,1,6));
    tbl.push_back(mk(1,1, 0,0,0,0,0, 0,0,0,1, 5'b10111, 2, 0,1,7));
    tbl.push_back(mk(1,1, 0,0,0,0,0, 0,0,0,1, 5'b10111, 3, 0,2,8));
    tbl.push_back(mk(1,1, 0,0,0,0,0, 0,0,0,0, 5'b11100, 3, 0,3,9));
    tbl.push_back(mk(1,1, 0,0,0,0,0, 0,0,0,0, 5'b11100, 3, 0,3,10));
    tbl.push_back(mk(1,1, 0,0,0,0,0, 0,1,1,0, 5'b10111, 2, 0,3,11));
    tbl.push_back(mk(1,0, 0,0,0,0,0, 0,0,0,0, 5'b00000, 3, 0,4,12));
    tbl.push_back(mk(1,0, 0,0,0,0,0, 0,0,0,0, 5'b00000, 0, 0,4,12));
    tbl.push_back(mk(1,1, 0,0,0,0,0, 0,0,0,0, 5'b00000, 0, 0,4,12));
    tbl.push_back(mk(1,1, 0,0,0,0,0, 0,0,0,0, 5'b11100, 1, 0,4,12));
    tbl.push_back(mk(1,1, 0,0,0,0,0, 0,0,0,0, 5'b11100, 1, 0,4,13));
    tbl.push_back(mk(1,1, 0,0,0,0,0, 0,0,0,0, 5'b11000, 2, 0,4,14));
    tbl.push_back(mk(1,1, 0,0,0,0,0, 0,1,1,0, 5'b10111, 2, 0,4,15));
    tbl.push_back(mk(1,1, 0,0,0,0,0, 0,0,0,0, 5'b11100, 3, 0,5,16));
    n_b = tbl.size();
    // dut_b replay after async reset mid-REDIRECT
    tbl.push_back(mk(1,1, 0,0,0,0,0, 0,0,0,0, 5'b00000, 0, 0,0,0));
    tbl.push_back(mk(1,1, 0,0,0,0,0, 0,0,0,0, 5'b11100, 1, 0,0,0));
    tbl.push_back(mk(1,1, 0,0,0,0,0, 0,0,0,0, 5'b11100, 1, 0,0,1));
    tbl.push_back(mk(1,1, 0,0,0,0,0, 0,0,0,0, 5'b11000, 2, 0,0,2));

    repeat (2) @(posedge clk);
    @(negedge clk);
    arst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < n_a; i++) apply(tbl[i], i);

    // Continuous load-use on dut_a: stall counter must stick at 15.
    en_a = 1'b1; en_b = 1'b0;
    id_rs1 = 5'd9; id_uses_rs1 = 1'b1; ex_rd = 5'd9; ex_mem_read = 1'b1;
    id_rs2 = '0; id_uses_rs2 = 1'b0; mem_branch = 1'b0; mem_zero = 1'b0; mem_jump = 1'b0;
    for (int k = 0; k < 20; k++) begin
      #1;
      chk("sat_stall_pc_en", k, 32'(pc_a), 32'd0);
      @(posedge clk);
      #1;
    end
    chk("sat_stall_cnt", 0, 32'(stall_a), 32'd15);
    chk("sat_flush_cnt", 0, 32'(flush_a), 32'd2);
    chk("sat_active_cnt", 0, 32'(active_a), 32'd15);

    for (int i = n_a; i < n_b; i++) apply(tbl[i], i);

    // dut_b now in REDIRECT with one bubble left; reset lands between edges.
    #2;
    arst_n = 1'b0;
    #1;
    chk("arst_state_b", 0, 32'(st_b), 32'd0);
    chk("arst_pc_en_b", 0, 32'(pc_b), 32'd0);
    chk("arst_flush_b", 0, flush_b, 32'd0);
    chk("arst_active_b", 0, active_b, 32'd0);
    chk("arst_stall_a", 0, 32'(stall_a), 32'd0);
    chk("arst_flush_a", 0, 32'(flush_a), 32'd0);
    chk("arst_active_a", 0, 32'(active_a), 32'd0);
    arst_n = 1'b1;
    en_b = 1'b0;
    @(posedge clk);
    #1;

    for (int i = n_b; i < tbl.size(); i++) apply(tbl[i], i);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Sequences the 5-stage RISC-V pipeline.
- Generates the PC enable, the IF/ID enable, and per-stage flush strobes that turn pipeline registers into bubbles.
- Detects load-use hazards (1-cycle stall) and branch/jump redirects resolved in MEM (flushes younger instructions).
- Inserts fetch-latency bubbles after start-up and after each redirect; keeps stall, flush and active-cycle performance counters.

Parameters:
IMEM_LAT, 1, instruction memory read latency in cycles; range 1..3; number of bubble cycles after start/redirect
CNT_W, 32, width of each performance counter

Ports:
clk  input  1  main clock
arst_n  input  1  asynchronous active-low reset
enable  input  1  run request; low freezes the pipeline
id_rs1  input  5  rs1 field of instruction in IF/ID
id_rs2  input  5  rs2 field of instruction in IF/ID
id_uses_rs1  input  1  IF/ID instruction reads rs1
id_uses_rs2  input  1  IF/ID instruction reads rs2
ex_rd  input  5  rd field of instruction in ID/EX
ex_mem_read  input  1  ID/EX instruction is a load
mem_branch  input  1  EX/MEM holds a branch
mem_zero  input  1  EX/MEM zero flag
mem_jump  input  1  EX/MEM holds a jump
pc_en  output  1  PC register update enable
if_id_en  output  1  IF/ID load enable
if_id_flush  output  1  IF/ID loads a bubble (all-zero instruction, controls 0)
id_ex_flush  output  1  ID/EX loads a bubble
ex_mem_flush  output  1  EX/MEM loads a bubble
ctrl_state  output  2  FSM state: 0 IDLE, 1 FILL, 2 RUN, 3 REDIRECT
stall_cnt  output  CNT_W  load-use stall cycles
flush_cnt  output  CNT_W  redirect events
active_cnt  output  CNT_W  cycles spent outside IDLE

Behaviour:
- Reset (arst_n low, asynchronous):
  - State is IDLE.
  - All counters are 0.
  - Combinational outputs follow from IDLE: pc_en=0, if_id_en=0, all flushes=0.
- Signal definitions:
  - redirect = mem_jump | (mem_branch & mem_zero).
  - load_use = ex_mem_read & (ex_rd != 0) & ((id_uses_rs1 & id_rs1 == ex_rd) | (id_uses_rs2 & id_rs2 == ex_rd)).
- Control outputs are combinational from the current state and the inputs, so they take effect in the same cycle.
- State, bubble counter and perf counters are registered.
- enable=0 in any state:
  - Next state is IDLE.
  - All control outputs are 0.
  - Counters hold.
  - The bubble counter is cleared.
- IDLE: outputs all 0. When enable=1, go to FILL with bubble_ctr=IMEM_LAT.
- FILL:
  - Outputs: pc_en=1, if_id_en=1, if_id_flush=1.
  - bubble_ctr decrements each cycle; at 1 go to RUN.
- RUN, in priority order:
  - redirect:
    - Outputs: pc_en=1, if_id_flush=1, id_ex_flush=1, ex_mem_flush=1.
    - flush_cnt+1.
    - Go to REDIRECT with bubble_ctr=IMEM_LAT.
  - else load_use:
    - Outputs: pc_en=0, if_id_en=0, id_ex_flush=1.
    - stall_cnt+1.
    - Stay in RUN; exactly one stall per hazard.
  - else: pc_en=1, if_id_en=1, no flush.
- REDIRECT:
  - Behaves like FILL: inserts IMEM_LAT bubbles into IF/ID.
  - load_use is masked, because bubbles carry uses flags = 0.
  - A new redirect in this state flushes again, increments flush_cnt and reloads bubble_ctr to IMEM_LAT.
  - At bubble_ctr 1 go to RUN.
- Simultaneous redirect and load_use: redirect wins; stall_cnt does not increment.
- active_cnt increments on every cycle with enable=1 and state != IDLE.
- All counters saturate at 2^CNT_W-1 and never wrap.
- Reset asserted mid-FILL/REDIRECT: state goes to IDLE immediately; on release, start-up replays from FILL.

Decomposition:
- Shared package constants: state encodings ST_IDLE/ST_FILL/ST_RUN/ST_REDIRECT (2 bits), REG_ZERO=5'd0, BUBBLE_INSTR=32'h0.
- One sub-module, sat_counter (parameter CNT_W; ports: clk, arst_n, inc, count), instantiated three times.

Test Plan:
- Reset, then enable=1 with IMEM_LAT=1:
  - cycle 0: ctrl_state=1, if_id_flush=1, pc_en=1.
  - cycle 1: ctrl_state=2, flushes 0.
  - active_cnt=2 after 2 cycles.
- RUN with ex_mem_read=1, ex_rd=5, id_rs2=5, id_uses_rs2=1:
  - exactly one cycle of pc_en=0, if_id_en=0, id_ex_flush=1.
  - stall_cnt=1.
  - same inputs with ex_rd=0: no stall.
- RUN with mem_branch=1, mem_zero=1:
  - all three flushes=1 for one cycle, flush_cnt=1.
  - with IMEM_LAT=2: two following cycles with if_id_flush=1, then RUN.
  - mem_branch=1, mem_zero=0: no flush.
- Same cycle mem_jump=1 and load_use true: flush only; stall_cnt unchanged; next state REDIRECT.
- enable dropped mid-REDIRECT: next cycle IDLE, all outputs 0, counters frozen. Re-enable: FILL replayed.
- CNT_W=4, 20 load-use stalls: stall_cnt stops at 15. Async reset mid-test: all counters 0 without waiting for a clock edge.
